// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl
//   LED output controller for the board top level. Drives NUM_LEDS LEDs, each
//   independently OFF / ON / BLINK / PWM, programmed through a valid/ready
//   write port. PWM duty writes land in a shadow register and are copied to
//   the active duty only when the PWM counter wraps, so a period is never cut
//   short or stretched by a duty change.
//
//   Optional feature macro: LED_PWM_EN
//     defined   : PWM counter, pending and active duty storage are built.
//     undefined : no PWM hardware. Mode 11 lights the LED when the duty written
//                 with it was nonzero (1 bit per channel); wr_duty is otherwise ignored.
//
// Ports
//   clk50     in   system clock, rising edge
//   rst_n     in   synchronous reset, active low
//   wr_valid  in   write request
//   wr_ready  out  controller can accept a write (low for the APPLY cycle)
//   wr_chan   in   target channel
//   wr_mode   in   00 OFF, 01 ON, 10 BLINK, 11 PWM
//   wr_duty   in   PWM duty, only meaningful with mode 11
//   wr_err    out  one-cycle pulse when an accepted write named a missing channel
//   LEDS      out  registered LED drive, 1 = lit
module led_bank_ctrl #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2,
    parameter int PWM_BITS = 8,
    localparam int CW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk50,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic                wr_err,
    output logic [NUM_LEDS-1:0] LEDS
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {
        IDLE,
        APPLY
    } state_t;

    state_t        state;
    logic [1:0]    mode [NUM_LEDS];
    logic [PW-1:0] prescaler;
    logic          blink_phase;
    logic          xfer;
    logic          chan_bad;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pend_duty [NUM_LEDS];
    logic [PWM_BITS-1:0] act_duty  [NUM_LEDS];
`else
    logic [NUM_LEDS-1:0] duty_nz;
`endif

    assign xfer     = wr_valid && wr_ready;
    assign chan_bad = (32'(wr_chan) >= NUM_LEDS);

    // Write FSM. The captured write is committed at the transfer edge so the
    // mode register already holds the new value during APPLY; APPLY itself is
    // the one-cycle recovery slot in which wr_ready is low and wr_err pulses.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ready <= 1'b0;
            wr_err   <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode[i] <= 2'b00;
`ifdef LED_PWM_EN
                pend_duty[i] <= '0;
`endif
            end
`ifndef LED_PWM_EN
            duty_nz <= '0;
`endif
        end else begin
            wr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state    <= APPLY;
                        wr_ready <= 1'b0;
                        if (chan_bad) begin
                            wr_err <= 1'b1;
                        end else begin
                            mode[wr_chan] <= wr_mode;
`ifdef LED_PWM_EN
                            pend_duty[wr_chan] <= wr_duty;
`else
                            duty_nz[wr_chan] <= |wr_duty;
`endif
                        end
                    end else begin
                        wr_ready <= 1'b1;
                    end
                end
                APPLY: begin
                    state    <= IDLE;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Shared timebase: one free-running prescaler keeps every BLINK channel in
    // phase; the PWM counter loads the shadow duties on its last count so the
    // new duty applies from count 0 of the next period.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            prescaler   <= '0;
            blink_phase <= 1'b0;
`ifdef LED_PWM_EN
            pwm_cnt <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                act_duty[i] <= '0;
            end
`endif
        end else begin
            if (prescaler == PW'(HALF - 1)) begin
                prescaler   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
`ifdef LED_PWM_EN
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    act_duty[i] <= pend_duty[i];
                end
            end
`endif
        end
    end

    // Output stage, one register after the mode register.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            LEDS <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                case (mode[i])
                    2'b00: LEDS[i] <= 1'b0;
                    2'b01: LEDS[i] <= 1'b1;
                    2'b10: LEDS[i] <= blink_phase;
`ifdef LED_PWM_EN
                    default: LEDS[i] <= (pwm_cnt < act_duty[i]);
`else
                    default: LEDS[i] <= duty_nz[i];
`endif
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// tb_led_bank_ctrl
//   Bench for led_bank_ctrl with NUM_LEDS=6, CLK_HZ=100, BLINK_HZ=5 (10-cycle
//   half period) and PWM_BITS=4. A behavioural model derives blink phase and
//   PWM count from the number of clocks since reset and is compared with the
//   DUT after every edge; directed sections pin literal values.
module tb_led_bank_ctrl;

    localparam int NL     = 6;
    localparam int HALF   = 10;
    localparam int PERIOD = 16;

    logic       clk50    = 1'b0;
    logic       rst_n    = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_chan  = '0;
    logic [1:0] wr_mode  = '0;
    logic [3:0] wr_duty  = '0;
    logic       wr_err;
    logic [5:0] LEDS;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int         n;
    bit         model_live = 1'b0;
    int         m_mode [NL];
    int         m_pend [NL];
    int         m_act  [NL];
    bit         m_nz   [NL];
    bit         m_ready;
    bit         m_err;
    logic [5:0] m_leds;
    logic [5:0] next_leds;
    bit         m_xfer;

    led_bank_ctrl #(
        .NUM_LEDS(NL),
        .CLK_HZ  (100),
        .BLINK_HZ(5),
        .PWM_BITS(4)
    ) dut (
        .clk50   (clk50),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_chan (wr_chan),
        .wr_mode (wr_mode),
        .wr_duty (wr_duty),
        .wr_err  (wr_err),
        .LEDS    (LEDS)
    );

    always #5 clk50 = ~clk50;

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Model step: n counts clocks since the reset edge, so the prescaler sits
    // at n%HALF, the blink phase is (n/HALF)%2 and the PWM count is n%PERIOD.
    always @(posedge clk50) begin
        if (!rst_n) begin
            model_live = 1'b1;
            n          = 0;
            m_ready    = 1'b0;
            m_err      = 1'b0;
            m_leds     = '0;
            for (int i = 0; i < NL; i++) begin
                m_mode[i] = 0;
                m_pend[i] = 0;
                m_act[i]  = 0;
                m_nz[i]   = 1'b0;
            end
        end else if (model_live) begin
            for (int i = 0; i < NL; i++) begin
                case (m_mode[i])
                    0: next_leds[i] = 1'b0;
                    1: next_leds[i] = 1'b1;
                    2: next_leds[i] = ((n / HALF) % 2) == 1;
`ifdef LED_PWM_EN
                    default: next_leds[i] = (n % PERIOD) < m_act[i];
`else
                    default: next_leds[i] = m_nz[i];
`endif
                endcase
            end
            n = n + 1;
            if (n % PERIOD == 0) begin
                for (int i = 0; i < NL; i++) m_act[i] = m_pend[i];
            end
            m_xfer = wr_valid && m_ready;
            m_err  = m_xfer && (int'(wr_chan) >= NL);
            if (m_xfer && int'(wr_chan) < NL) begin
                m_mode[wr_chan] = int'(wr_mode);
                m_pend[wr_chan] = int'(wr_duty);
                m_nz[wr_chan]   = (wr_duty != 0);
            end
            m_ready = !m_xfer;
            m_leds  = next_leds;
        end
        #1;
        if (model_live) begin
            check_output("model_leds", int'(LEDS), int'(m_leds));
            check_output("model_wr_ready", int'(wr_ready), int'(m_ready));
            check_output("model_wr_err", int'(wr_err), int'(m_err));
        end
    end

    // Issues one write; returns at the falling edge inside the APPLY cycle.
    task automatic apply_stimulus(input int chan, input int mode, input int duty);
        int waited;
        waited = 0;
        @(negedge clk50);
        while (wr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk50);
            waited++;
        end
        if (wr_ready !== 1'b1) check_output("ready_timeout", int'(wr_ready), 1);
        wr_valid = 1'b1;
        wr_chan  = 3'(chan);
        wr_mode  = 2'(mode);
        wr_duty  = 4'(duty);
        @(posedge clk50);
        @(negedge clk50);
        wr_valid = 1'b0;
        wr_chan  = 3'($urandom_range(0, 7));
        wr_mode  = 2'($urandom_range(0, 3));
        wr_duty  = 4'($urandom_range(0, 15));
    endtask

    // Counts LEDS[1] high samples over one PWM period aligned to count 0.
    task automatic count_period(output int highs);
        int guard;
        guard = 0;
        highs = 0;
        repeat (2) @(negedge clk50);
        while ((n % PERIOD) != 1 && guard < 40) begin
            @(negedge clk50);
            guard++;
        end
        if ((n % PERIOD) != 1) check_output("period_align", n % PERIOD, 1);
        for (int k = 0; k < PERIOD; k++) begin
            highs += int'(LEDS[1]);
            @(negedge clk50);
        end
    endtask

    initial begin
        int   highs;
        int   toggles;
        logic prev;

        // Reset for three cycles.
        repeat (3) begin
            @(negedge clk50);
            check_output("reset_leds", int'(LEDS), 0);
            check_output("reset_ready", int'(wr_ready), 0);
        end
        rst_n = 1'b1;
        check_output("ready_first_cycle", int'(wr_ready), 0);
        @(negedge clk50);
        check_output("ready_after_release", int'(wr_ready), 1);

        // Single ON write.
        apply_stimulus(2, 1, 0);
        check_output("on_ready_apply", int'(wr_ready), 0);
        @(negedge clk50);
        check_output("on_leds", int'(LEDS), 6'b000100);
        check_output("on_ready_back", int'(wr_ready), 1);

        // Two BLINK channels in phase, toggling every HALF cycles.
        apply_stimulus(0, 2, 0);
        apply_stimulus(5, 2, 0);
        repeat (2) @(negedge clk50);
        toggles = 0;
        prev    = LEDS[0];
        for (int k = 0; k < 40; k++) begin
            @(negedge clk50);
            check_output("blink_in_phase", int'(LEDS[5]), int'(LEDS[0]));
            if (LEDS[0] !== prev) toggles++;
            prev = LEDS[0];
        end
        check_output("blink_toggles", toggles, 4);

        // PWM channel 1: duty 4 then duty 12, both written mid-period.
        repeat (5) @(negedge clk50);
        apply_stimulus(1, 3, 4);
`ifdef LED_PWM_EN
        count_period(highs);
        check_output("pwm_duty4_highs", highs, 4);
        repeat (7) @(negedge clk50);
        apply_stimulus(1, 3, 12);
        count_period(highs);
        check_output("pwm_duty12_highs", highs, 12);
`else
        @(negedge clk50);
        check_output("nopwm_nz_on", int'(LEDS[1]), 1);
        repeat (5) @(negedge clk50);
        check_output("nopwm_nz_steady", int'(LEDS[1]), 1);
        apply_stimulus(1, 3, 0);
        @(negedge clk50);
        check_output("nopwm_zero_off", int'(LEDS[1]), 0);
`endif

        // Out-of-range channel.
        apply_stimulus(7, 1, 0);
        check_output("err_pulse", int'(wr_err), 1);
        @(negedge clk50);
        check_output("err_cleared", int'(wr_err), 0);
        check_output("err_leds_kept", int'(LEDS[4:2]), 3'b001);
        apply_stimulus(4, 1, 0);
        @(negedge clk50);
        check_output("after_err_write", int'(LEDS[4]), 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 80; k++) begin
            apply_stimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 6)) @(negedge clk50);
        end

        // Reset during APPLY discards the write.
        apply_stimulus(3, 1, 0);
        rst_n = 1'b0;
        @(negedge clk50);
        check_output("midwrite_reset_leds", int'(LEDS), 0);
        check_output("midwrite_reset_ready", int'(wr_ready), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk50);
        check_output("midwrite_chan3_off", int'(LEDS[3]), 0);
        check_output("midwrite_all_off", int'(LEDS), 0);

        repeat (2) @(negedge clk50);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
